// File: rtl/mod_inv_pkg.sv
// mod_inv_pkg: shared constants and types for the Fermat modular inverter.
//   Q_DIL / Q_KYB       moduli for Dilithium and Kyber
//   EXP_DIL / EXP_KYB   inversion exponents (q - 2)
//   NBITS_DIL/NBITS_KYB exponent lengths
//   MU_DIL / MU_KYB     Barrett constants floor(2^K / q)
//   state_e, phase_e    controller state and square/multiply phase
package mod_inv_pkg;

    localparam logic [22:0] Q_DIL   = 23'd8380417;
    localparam logic [11:0] Q_KYB   = 12'd3329;
    localparam logic [22:0] EXP_DIL = 23'h7FDFFF;
    localparam logic [11:0] EXP_KYB = 12'hCFF;

    localparam int unsigned NBITS_DIL = 23;
    localparam int unsigned NBITS_KYB = 12;

    // Barrett shifts: products stay below 2^46 (Dilithium) and 2^24 (Kyber).
    localparam int unsigned K_DIL = 46;
    localparam int unsigned K_KYB = 24;

    localparam logic [23:0] MU_DIL = 24'((64'd1 << K_DIL) / 64'(Q_DIL));
    localparam logic [12:0] MU_KYB = 13'((64'd1 << K_KYB) / 64'(Q_KYB));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic {
        SQR,
        MUL
    } phase_e;

endpackage

// File: rtl/mod_inv_barrett_mul.sv
// barrett_mul: combinational modular multiplier z = x * y mod q.
//   x_i, y_i  23-bit operands, each < selected q
//   sel_i     0 = Dilithium q, 1 = Kyber q (operands then fit in 12 bits)
//   z_o       reduced product, Kyber result zero-extended
module barrett_mul
    import mod_inv_pkg::*;
(
    input  logic [22:0] x_i,
    input  logic [22:0] y_i,
    input  logic        sel_i,
    output logic [22:0] z_o
);

    logic [45:0] prod;

    logic [23:0] t_dil;
    logic [23:0] r_dil;
    logic [22:0] z_dil;

    logic [11:0] t_kyb;
    logic [12:0] r_kyb;
    logic [11:0] z_kyb;

    always_comb begin
        prod = 46'(x_i) * 46'(y_i);

        // The quotient estimate undershoots by at most one, so the remainder
        // is below 2q and a single conditional subtraction finishes it.
        t_dil = 24'((70'(prod) * 70'(MU_DIL)) >> K_DIL);
        r_dil = 24'(48'(prod) - 48'(t_dil) * 48'(Q_DIL));
        if (r_dil >= 24'(Q_DIL)) begin
            z_dil = 23'(r_dil - 24'(Q_DIL));
        end else begin
            z_dil = 23'(r_dil);
        end

        t_kyb = 12'((37'(prod[23:0]) * 37'(MU_KYB)) >> K_KYB);
        r_kyb = 13'(24'(prod[23:0]) - 24'(t_kyb) * 24'(Q_KYB));
        if (r_kyb >= 13'(Q_KYB)) begin
            z_kyb = 12'(r_kyb - 13'(Q_KYB));
        end else begin
            z_kyb = 12'(r_kyb);
        end

        z_o = sel_i ? {11'b0, z_kyb} : z_dil;
    end

endmodule

// File: rtl/mod_inv.sv
// mod_inv: sequential modular inverter, c = a^(q-2) mod q, computed by
// left-to-right square-and-multiply over one shared Barrett multiplier.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i/ready_o    operand handshake (a_i, select_i sampled at accept)
//   a_i                operand, select_i: 0 = Dilithium, 1 = Kyber
//   valid_o/ready_i    result handshake
//   c_o                inverse (0 on error), err_o: operand not invertible
// Build option: MOD_INV_FAST_EN skips MUL cycles for zero exponent bits.
module mod_inv
    import mod_inv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [22:0] a_i,
    input  logic        select_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [22:0] c_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic        sel_q,   sel_d;
    logic        err_q,   err_d;
    logic [22:0] base_q,  base_d;
    logic [22:0] acc_q,   acc_d;
    logic [4:0]  bit_q,   bit_d;

    logic [22:0] q_in;
    logic        a_bad;
    logic [22:0] exp_word;
    logic        exp_bit;
    logic [22:0] mul_y;
    logic [22:0] mul_z;

    always_comb begin
        q_in     = select_i ? {11'b0, Q_KYB} : Q_DIL;
        a_bad    = (a_i == 23'd0) || (a_i >= q_in);
        exp_word = sel_q ? {11'b0, EXP_KYB} : EXP_DIL;
        exp_bit  = exp_word[bit_q];
        // Multiplier runs every cycle; only the second operand changes.
        mul_y    = (phase_q == SQR) ? acc_q : base_q;
    end

    barrett_mul u_barrett_mul (
        .x_i   (acc_q),
        .y_i   (mul_y),
        .sel_i (sel_q),
        .z_o   (mul_z)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sel_d   = sel_q;
        err_d   = err_q;
        base_d  = base_q;
        acc_d   = acc_q;
        bit_d   = bit_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    // An invalid operand is replaced by 0 so base stays < q;
                    // the run still takes the full schedule.
                    base_d  = a_bad ? 23'd0 : a_i;
                    sel_d   = select_i;
                    err_d   = a_bad;
                    acc_d   = 23'd1;
                    bit_d   = select_i ? 5'(NBITS_KYB - 1) : 5'(NBITS_DIL - 1);
                    phase_d = SQR;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (phase_q == SQR) begin
                    acc_d = mul_z;
`ifdef MOD_INV_FAST_EN
                    if (!exp_bit) begin
                        if (bit_q == 5'd0) begin
                            state_d = DONE;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end else begin
                        phase_d = MUL;
                    end
`else
                    phase_d = MUL;
`endif
                end else begin
                    if (exp_bit) begin
                        acc_d = mul_z;
                    end
                    phase_d = SQR;
                    if (bit_q == 5'd0) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q - 5'd1;
                    end
                end
            end

            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            phase_q <= SQR;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= 23'd0;
            acc_q   <= 23'd0;
            bit_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
        c_o     = (valid_o && !err_q) ? acc_q : 23'd0;
        err_o   = valid_o && err_q;
    end

endmodule
